// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: unit indices, reserved tag, widths.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_UNITS = 5;
    localparam int CDB_TAG_W     = 8;
    localparam int CDB_DATA_W    = 32;
    localparam int CDB_W         = CDB_TAG_W + CDB_DATA_W;
    localparam int CDB_MAX_WAIT  = 7;

    localparam int UNIT_LW  = 0;
    localparam int UNIT_SW  = 1;
    localparam int UNIT_ADD = 2;
    localparam int UNIT_MUL = 3;
    localparam int UNIT_MV  = 4;

    // Tag meaning "no pending producer"; never a legal result tag on the bus.
    localparam logic [CDB_TAG_W-1:0] NO_TAG = 8'h7F;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BCAST = 1'b1
    } cdb_state_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set mask bit scanning upward from rr, wrapping.
module cdb_arbiter_rr_pick #(
    parameter int N    = 5,
    parameter int RR_W = 3
) (
    input  logic [N-1:0]    mask,
    input  logic [RR_W-1:0] rr,
    output logic [N-1:0]    onehot,
    output logic            any
);

    int idx_s;

    // Scan N positions starting at rr; the first set bit wins.
    always_comb begin
        onehot = '0;
        any    = 1'b0;
        idx_s  = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(rr) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!any && mask[idx_s]) begin
                onehot[idx_s] = 1'b1;
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one functional-unit result broadcast per cycle, round-robin.
// Optional starvation guard enabled by defining CDB_STARVE_GUARD_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = CDB_NUM_UNITS,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int MAX_WAIT  = CDB_MAX_WAIT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_UNITS-1:0]        req,
    input  logic [NUM_UNITS*TAG_W-1:0]  tag_in,
    input  logic [NUM_UNITS*DATA_W-1:0] data_in,
    output logic [NUM_UNITS-1:0]        grant,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic                        err_tag
);

    localparam int RR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [TAG_W-1:0] NO_TAG_S = TAG_W'(NO_TAG);

    cdb_state_e             state_r, state_nx_s;
    logic [RR_W-1:0]        rr_r, rr_nx_s;
    logic [NUM_UNITS-1:0]   grant_r;
    logic [TAG_W-1:0]       cdb_tag_r;
    logic [DATA_W-1:0]      cdb_data_r;
    logic                   err_tag_r;

    logic [NUM_UNITS-1:0]   elig_s;
    logic [NUM_UNITS-1:0]   pick_oh_s;
    logic                   pick_any_s;
    logic [NUM_UNITS-1:0]   win_oh_s;
    logic                   win_any_s;
    logic [RR_W-1:0]        win_idx_s;
    logic [TAG_W-1:0]       win_tag_s;
    logic [DATA_W-1:0]      win_data_s;
    logic                   rsvd_s;
    logic                   bcast_s;

    // A unit granted last cycle may still show its old result, so it sits out this edge.
    assign elig_s = req & ~grant_r;

    cdb_arbiter_rr_pick #(
        .N    (NUM_UNITS),
        .RR_W (RR_W)
    ) u_rr_pick (
        .mask   (elig_s),
        .rr     (rr_r),
        .onehot (pick_oh_s),
        .any    (pick_any_s)
    );

`ifdef CDB_STARVE_GUARD_EN
    logic [2:0]           wait_cnt_r [NUM_UNITS];
    logic [NUM_UNITS-1:0] starve_s;
    logic [NUM_UNITS-1:0] starve_oh_s;

    // Starved units override round-robin; lowest index wins among them.
    always_comb begin
        starve_s    = '0;
        starve_oh_s = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            starve_s[i] = elig_s[i] && (wait_cnt_r[i] >= 3'(MAX_WAIT));
        end
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (starve_s[i]) begin
                starve_oh_s    = '0;
                starve_oh_s[i] = 1'b1;
            end else begin
                starve_oh_s = starve_oh_s;
            end
        end
        if (|starve_s) begin
            win_oh_s  = starve_oh_s;
            win_any_s = 1'b1;
        end else begin
            win_oh_s  = pick_oh_s;
            win_any_s = pick_any_s;
        end
    end

    // Saturating per-unit wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wait_cnt_r[i] <= 3'd0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!req[i] || win_oh_s[i]) begin
                    wait_cnt_r[i] <= 3'd0;
                end else if (wait_cnt_r[i] != 3'd7) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + 3'd1;
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end
    end
`else
    assign win_oh_s  = pick_oh_s;
    assign win_any_s = pick_any_s;
`endif

    // Winner index and its result fields.
    always_comb begin
        win_idx_s  = '0;
        win_tag_s  = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (win_oh_s[i]) begin
                win_idx_s  = RR_W'(i);
                win_tag_s  = tag_in[i*TAG_W +: TAG_W];
                win_data_s = data_in[i*DATA_W +: DATA_W];
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Reserved-tag winners are acknowledged but never put on the bus.
    assign rsvd_s  = win_any_s && (win_tag_s == NO_TAG_S);
    assign bcast_s = win_any_s && !rsvd_s;

    // Next-state and round-robin pointer update.
    always_comb begin
        state_nx_s = state_r;
        rr_nx_s    = rr_r;
        case (state_r)
            ST_IDLE: begin
                if (bcast_s) begin
                    state_nx_s = ST_BCAST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BCAST: begin
                if (bcast_s) begin
                    state_nx_s = ST_BCAST;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        if (win_any_s) begin
            if (win_idx_s == RR_W'(NUM_UNITS - 1)) begin
                rr_nx_s = '0;
            end else begin
                rr_nx_s = win_idx_s + RR_W'(1);
            end
        end else begin
            rr_nx_s = rr_r;
        end
    end

    // State, pointer and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_r       <= '0;
            grant_r    <= '0;
            cdb_tag_r  <= NO_TAG_S;
            cdb_data_r <= '0;
            err_tag_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            rr_r      <= rr_nx_s;
            grant_r   <= win_oh_s;
            cdb_tag_r <= bcast_s ? win_tag_s : NO_TAG_S;
            if (bcast_s) begin
                cdb_data_r <= win_data_s;
            end else begin
                cdb_data_r <= cdb_data_r;
            end
            err_tag_r <= err_tag_r | rsvd_s;
        end
    end

    assign grant     = grant_r;
    assign cdb_valid = (state_r == ST_BCAST);
    assign cdb_tag   = cdb_tag_r;
    assign cdb_data  = cdb_data_r;
    assign err_tag   = err_tag_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (default build, round-robin only).
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [4:0]   req;
    logic [39:0]  tag_in;
    logic [159:0] data_in;
    logic [4:0]   grant;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         err_tag;

    int total;
    int bad;

    cdb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tag_in    (tag_in),
        .data_in   (data_in),
        .grant     (grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .err_tag   (err_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] exp_data);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_valid"}, 32'(cdb_valid), 32'h0);
        chk({tag, "_tag"}, 32'(cdb_tag), 32'h7F);
        chk({tag, "_data"}, cdb_data, exp_data);
    endtask

    task automatic set_unit(input int u, input logic [7:0] t, input logic [31:0] d);
        tag_in[u*8 +: 8]    = t;
        data_in[u*32 +: 32] = d;
    endtask

    initial begin
        int order [6];
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        req     = 5'b00000;
        tag_in  = 40'h0;
        data_in = 160'h0;
        order   = '{0, 1, 2, 3, 4, 0};

        // Reset values.
        #12;
        chk_idle("reset", 32'd0);
        chk("reset_err", 32'(err_tag), 32'h0);

        // Single add request: one-cycle broadcast, then idle with data held.
        rst_n = 1'b1;
        req   = 5'b00100;
        set_unit(UNIT_ADD, 8'h12, 32'd42);
        tick();
        chk("add_grant", 32'(grant), 32'h04);
        chk("add_valid", 32'(cdb_valid), 32'h1);
        chk("add_tag", 32'(cdb_tag), 32'h12);
        chk("add_data", cdb_data, 32'd42);
        req = 5'b00000;
        tick();
        chk_idle("add_after", 32'd42);

        // All five requesting from rr=0: strict rotation, bus busy every cycle.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_unit(i, 8'h20 + 8'(i), 32'd100 + 32'(i));
        end
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rot%0d_grant", k), 32'(grant), 32'(5'b00001 << order[k]));
            chk($sformatf("rot%0d_valid", k), 32'(cdb_valid), 32'h1);
            chk($sformatf("rot%0d_tag", k), 32'(cdb_tag), 32'h20 + 32'(order[k]));
        end

        // Lone mul requester: served every other cycle.
        req = 5'b01000;
        tick();
        chk("mul1_grant", 32'(grant), 32'h08);
        chk("mul1_valid", 32'(cdb_valid), 32'h1);
        tick();
        chk("mul2_grant", 32'(grant), 32'h00);
        chk("mul2_valid", 32'(cdb_valid), 32'h0);
        tick();
        chk("mul3_grant", 32'(grant), 32'h08);
        chk("mul3_valid", 32'(cdb_valid), 32'h1);
        chk("mul3_data", cdb_data, 32'd103);

        // Reserved tag from sw: granted, not broadcast, sticky error.
        req = 5'b00010;
        set_unit(UNIT_SW, 8'h7F, 32'hDEAD);
        tick();
        chk("rsvd_grant", 32'(grant), 32'h02);
        chk("rsvd_valid", 32'(cdb_valid), 32'h0);
        chk("rsvd_tag", 32'(cdb_tag), 32'h7F);
        chk("rsvd_data", cdb_data, 32'd103);
        chk("rsvd_err", 32'(err_tag), 32'h1);
        req = 5'b00000;
        tick();
        tick();
        chk("rsvd_err_sticky", 32'(err_tag), 32'h1);
        chk("rsvd_idle_grant", 32'(grant), 32'h00);

        // Mid-stream async reset; afterwards pending units re-served from unit 0.
        set_unit(UNIT_SW, 8'h21, 32'd101);
        req = 5'b00011;
        tick();
        chk("pre_rst_grant", 32'(grant), 32'h01);
        chk("pre_rst_valid", 32'(cdb_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst", 32'd0);
        chk("async_rst_err", 32'(err_tag), 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst0_grant", 32'(grant), 32'h01);
        chk("post_rst0_tag", 32'(cdb_tag), 32'h20);
        chk("post_rst0_data", cdb_data, 32'd100);
        tick();
        chk("post_rst1_grant", 32'(grant), 32'h02);
        chk("post_rst1_valid", 32'(cdb_valid), 32'h1);
        chk("post_rst1_tag", 32'(cdb_tag), 32'h21);

        // New request arriving as another unit is granted competes normally.
        req = 5'b10001;
        set_unit(UNIT_MV, 8'h44, 32'd77);
        tick();
        chk("arrive_grant", 32'(grant), 32'h10);
        chk("arrive_tag", 32'(cdb_tag), 32'h44);
        req = 5'b00001;
        tick();
        chk("arrive_next_grant", 32'(grant), 32'h01);
        req = 5'b00000;
        tick();
        chk_idle("final_idle", 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
